fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NSRC, default 2: number of decode-stage register read ports.
REQ-002 Parameter NSTG, default 3: number of forwarding stages, index 0 = youngest (EX) to NSTG-1 = oldest (WB).
REQ-003 Parameter AW, default 5: register address width; register 0 is hardwired zero.
REQ-004 Parameter NLONG, default 4: maximum number of outstanding long-latency writes.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 ds_raddr  input  NSRC*AW  decode read addresses; port i occupies bits [i*AW +: AW].
REQ-008 ds_ren  input  NSRC  per-port read enable.
REQ-009 ds_issue  input  1  decode instruction advances to EX this cycle.
REQ-010 ds_dest  input  AW  decode instruction destination.
REQ-011 ds_we  input  1  decode instruction writes a register.
REQ-012 ds_long  input  1  decode instruction is long-latency (load miss path or divide), with its result returned via lw_*.
REQ-013 st_valid, st_we, st_rdy  input  NSTG each  per-stage valid, register write, and result-available-for-forwarding flags.
REQ-014 st_dest  input  NSTG*AW  per-stage destination.
REQ-015 lw_done  input  1  long-latency result written back this cycle.
REQ-016 lw_dest  input  AW  destination of the completing long op.
REQ-017 flush  input  1  pipeline flush; no older long op is outstanding when asserted.
REQ-018 fw_sel  output  NSRC*(NSTG+1)  registered one-hot select per port; bit k<NSTG = stage k, bit NSTG = register file.
REQ-019 ds_stall  output  1  combinational decode stall.
REQ-020 sb_cnt  output  clog2(NLONG+1)  outstanding long-op count.

Function
REQ-021 Port i matches stage k when ds_ren[i] & st_valid[k] & st_we[k] & st_dest[k]==raddr[i] & raddr[i]!=0.
REQ-022 The selected stage for port i SHALL be the lowest-index matching stage; with no match, the register file is selected.
REQ-023 The unit SHALL raise a RAW stall on port i when its selected stage has st_rdy=0.
REQ-024 The scoreboard holds one bit per register; a RAW stall SHALL also be raised when the port reads register r, sb[r]=1, and no stage matches.
REQ-025 ds_stall SHALL also assert on a WAW hazard: ds_we & ds_dest!=0 & sb[ds_dest]=1.
REQ-026 ds_stall SHALL also assert on a full scoreboard: ds_long & ds_we & sb_cnt==NLONG.
REQ-027 ds_stall SHALL be the OR of all hazard terms (RAW, WAW, full) and is independent of ds_issue.
REQ-028 On ds_issue & !ds_stall, fw_sel SHALL load the computed selects, visible in the following cycle (1-cycle latency); otherwise fw_sel SHALL hold its value.
REQ-029 The scoreboard bit sb[ds_dest] SHALL be set on ds_issue & !ds_stall & ds_long & ds_we & ds_dest!=0.
REQ-030 The scoreboard bit sb[lw_dest] SHALL be cleared on lw_done; if lw_dest is not set, the event is ignored and sb_cnt is unchanged.
REQ-031 When a set and a clear target the same register in one cycle, the set SHALL win; sb_cnt is then unchanged.
REQ-032 sb_cnt SHALL equal the popcount of the scoreboard at all times and SHALL never wrap.
REQ-033 flush SHALL clear all scoreboard bits, set sb_cnt to 0, and set fw_sel to register-file selects; it overrides set, clear and issue in the same cycle.

Reset
REQ-034 With resetn low, the scoreboard SHALL be all zero, sb_cnt SHALL be 0, and every fw_sel port SHALL select the register file (bit NSTG).
REQ-035 Reset assertion mid-operation SHALL take effect immediately and asynchronously; all state SHALL be restored on deassertion with no residual stall.

Structure
REQ-036 The select-encoding constants (width NSTG+1, the register-file index) and the default parameter values SHALL live in the shared mycpu package.
REQ-037 Per-port match, priority and stall logic SHALL be a sub-module fwd_port_sel, instantiated NSRC times via generate.

Verification
REQ-038 Stage0 {valid,we,rdy}=1, dest=5, port0 reads 5, issue -> next cycle fw_sel port0 = 0001, ds_stall=0.
REQ-039 Stage0 and stage2 both write 7, port1 reads 7 -> stage0 selected; stage0 rdy=0 -> ds_stall=1 and fw_sel holds.
REQ-040 Issue long op to r9 -> sb_cnt=1; read r9 with no stage match -> stall; lw_done r9 -> stall clears next cycle, sb_cnt=0.
REQ-041 Issue 4 long ops (r1-r4) -> 5th long op stalls; same-cycle lw_done r2 plus issue long r2 -> sb[2]=1, sb_cnt=4.
REQ-042 Port reads r0 with stage dest 0 -> register file selected, no stall; issue long op to r0 -> sb_cnt unchanged.
REQ-043 Flush or resetn pulse with sb_cnt=3 -> sb_cnt=0, all fw_sel = 1000, ds_stall=0.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared definitions for the forwarding/hazard slice.
// Holds the default parameter values and the fw_sel encoding helpers.
// Each select is one-hot, NSTG+1 bits wide. Bit k (k < NSTG) selects
// pipeline stage k, and bit NSTG selects the register file.
package mycpu_pkg;

    localparam int unsigned NSRC_DEF  = 2;
    localparam int unsigned NSTG_DEF  = 3;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned NLONG_DEF = 4;

    // Width of one port's one-hot forwarding select
    function automatic int unsigned fw_sel_w(input int unsigned nstg);
        return nstg + 1;
    endfunction

    // Bit position of the register-file source within a select
    function automatic int unsigned fw_rf_idx(input int unsigned nstg);
        return nstg;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding select and RAW stall detection.
// Ports:
//   raddr_i    - read address of this port
//   ren_i      - read enable of this port
//   st_valid_i - per-stage valid flag
//   st_we_i    - per-stage register-write flag
//   st_rdy_i   - per-stage result-ready flag
//   st_dest_i  - per-stage destination address (stage k at [k*AW +: AW])
//   sb_i       - scoreboard, one bit per register
//   sel_o      - one-hot select (stage k, or bit NSTG for the register file)
//   raw_o      - RAW hazard on this port
module fwd_port_sel
    import mycpu_pkg::*;
#(
    parameter int unsigned NSTG = NSTG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic [AW-1:0]               raddr_i,
    input  logic                        ren_i,
    input  logic [NSTG-1:0]             st_valid_i,
    input  logic [NSTG-1:0]             st_we_i,
    input  logic [NSTG-1:0]             st_rdy_i,
    input  logic [NSTG*AW-1:0]          st_dest_i,
    input  logic [(1<<AW)-1:0]          sb_i,
    output logic [fw_sel_w(NSTG)-1:0]   sel_o,
    output logic                        raw_o
);

    localparam int unsigned RF = fw_rf_idx(NSTG);

    logic found;

    // The youngest matching stage wins, so the scan runs from stage 0 upward
    // and stops at the first hit.
    always_comb begin
        found = 1'b0;
        sel_o = '0;
        raw_o = 1'b0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            if (!found && ren_i && (raddr_i != '0) && st_valid_i[k] && st_we_i[k]
                && (st_dest_i[k*AW +: AW] == raddr_i)) begin
                found    = 1'b1;
                sel_o[k] = 1'b1;
                raw_o    = !st_rdy_i[k];
            end
        end
        if (!found) begin
            sel_o[RF] = 1'b1;
            raw_o     = ren_i && (raddr_i != '0) && sb_i[raddr_i];
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding select and hazard unit.
// Ports:
//   clk, resetn         - clock and asynchronous active-low reset
//   ds_raddr / ds_ren   - decode read addresses and enables (port i at [i*AW +: AW])
//   ds_issue            - decode instruction advances to EX
//   ds_dest / ds_we     - decode destination and write enable
//   ds_long             - decode instruction is long-latency
//   st_valid/we/rdy     - per-stage flags; st_dest is the per-stage destination
//   lw_done / lw_dest   - long-latency writeback completion
//   flush               - pipeline flush
//   fw_sel              - registered one-hot selects, NSRC x (NSTG+1)
//   ds_stall            - combinational decode stall
//   sb_cnt              - outstanding long-op count
module fwd_hazard_unit
    import mycpu_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned NSTG  = NSTG_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned NLONG = NLONG_DEF
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NSRC*AW-1:0]                ds_raddr,
    input  logic [NSRC-1:0]                   ds_ren,
    input  logic                              ds_issue,
    input  logic [AW-1:0]                     ds_dest,
    input  logic                              ds_we,
    input  logic                              ds_long,
    input  logic [NSTG-1:0]                   st_valid,
    input  logic [NSTG-1:0]                   st_we,
    input  logic [NSTG-1:0]                   st_rdy,
    input  logic [NSTG*AW-1:0]                st_dest,
    input  logic                              lw_done,
    input  logic [AW-1:0]                     lw_dest,
    input  logic                              flush,
    output logic [NSRC*fw_sel_w(NSTG)-1:0]    fw_sel,
    output logic                              ds_stall,
    output logic [$clog2(NLONG+1)-1:0]        sb_cnt
);

    localparam int unsigned SW   = fw_sel_w(NSTG);
    localparam int unsigned RF   = fw_rf_idx(NSTG);
    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = $clog2(NLONG + 1);

    logic [NREG-1:0]    sb_q, sb_d, sb_eff, clr_vec, set_vec;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_eff;
    logic [NSRC*SW-1:0] fw_q, fw_d, sel_all, rf_all;
    logic [NSRC-1:0]    raw_vec;
    logic               clr_ok, set_ok, accept, waw, full;

    for (genvar i = 0; i < NSRC; i++) begin : g_port
        fwd_port_sel #(
            .NSTG (NSTG),
            .AW   (AW)
        ) u_sel (
            .raddr_i    (ds_raddr[i*AW +: AW]),
            .ren_i      (ds_ren[i]),
            .st_valid_i (st_valid),
            .st_we_i    (st_we),
            .st_rdy_i   (st_rdy),
            .st_dest_i  (st_dest),
            .sb_i       (sb_eff),
            .sel_o      (sel_all[i*SW +: SW]),
            .raw_o      (raw_vec[i])
        );
    end

    always_comb begin
        rf_all = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            rf_all[i*SW + RF] = 1'b1;
        end
    end

    // A completion this cycle is applied before hazard checks, so a register
    // freed by lw_done can be re-reserved in the same cycle (set wins).
    assign clr_ok = lw_done && (lw_dest != '0) && sb_q[lw_dest];

    always_comb begin
        clr_vec = '0;
        if (clr_ok) clr_vec[lw_dest] = 1'b1;
    end

    assign sb_eff  = sb_q & ~clr_vec;
    assign cnt_eff = cnt_q - CW'(clr_ok);

    assign waw      = ds_we && (ds_dest != '0) && sb_eff[ds_dest];
    assign full     = ds_long && ds_we && (cnt_eff == CW'(NLONG));
    assign ds_stall = (|raw_vec) || waw || full;

    assign accept = ds_issue && !ds_stall;
    assign set_ok = accept && ds_long && ds_we && (ds_dest != '0);

    always_comb begin
        set_vec = '0;
        if (set_ok) set_vec[ds_dest] = 1'b1;
    end

    // WAW guarantees the set bit is clear in sb_eff, so the count only grows by one
    always_comb begin
        if (flush) begin
            sb_d  = '0;
            cnt_d = '0;
            fw_d  = rf_all;
        end else begin
            sb_d  = sb_eff | set_vec;
            cnt_d = cnt_eff + CW'(set_ok);
            fw_d  = accept ? sel_all : fw_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_q  <= '0;
            cnt_q <= '0;
            fw_q  <= rf_all;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            fw_q  <= fw_d;
        end
    end

    assign fw_sel = fw_q;
    assign sb_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int NSRC  = 2;
    localparam int NSTG  = 3;
    localparam int AW    = 5;
    localparam int NLONG = 4;
    localparam int SW    = NSTG + 1;
    localparam logic [7:0] RF_ALL = 8'b1000_1000;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NSRC*AW-1:0]   ds_raddr;
    logic [NSRC-1:0]      ds_ren;
    logic                 ds_issue;
    logic [AW-1:0]        ds_dest;
    logic                 ds_we;
    logic                 ds_long;
    logic [NSTG-1:0]      st_valid, st_we, st_rdy;
    logic [NSTG*AW-1:0]   st_dest;
    logic                 lw_done;
    logic [AW-1:0]        lw_dest;
    logic                 flush;
    logic [NSRC*SW-1:0]   fw_sel;
    logic                 ds_stall;
    logic [2:0]           sb_cnt;

    fwd_hazard_unit #(
        .NSRC  (NSRC),
        .NSTG  (NSTG),
        .AW    (AW),
        .NLONG (NLONG)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ds_raddr (ds_raddr),
        .ds_ren   (ds_ren),
        .ds_issue (ds_issue),
        .ds_dest  (ds_dest),
        .ds_we    (ds_we),
        .ds_long  (ds_long),
        .st_valid (st_valid),
        .st_we    (st_we),
        .st_rdy   (st_rdy),
        .st_dest  (st_dest),
        .lw_done  (lw_done),
        .lw_dest  (lw_dest),
        .flush    (flush),
        .fw_sel   (fw_sel),
        .ds_stall (ds_stall),
        .sb_cnt   (sb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [7:0]  fw;
        int          cnt;
        logic [31:0] sb;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_sb;
    logic [7:0]  m_fw;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ds_raddr = '0; ds_ren = '0; ds_issue = 1'b0; ds_dest = '0;
        ds_we = 1'b0; ds_long = 1'b0; st_valid = '0; st_we = '0;
        st_rdy = '0; st_dest = '0; lw_done = 1'b0; lw_dest = '0; flush = 1'b0;
    endtask

    // Reference behaviour: stall for the current inputs and the state after the edge
    task automatic model_eval(output logic stall, output logic [31:0] sbn, output logic [7:0] fwn);
        logic [31:0] eff;
        logic [7:0]  sel;
        logic [4:0]  r;
        int          hit;
        eff = m_sb;
        if (lw_done) eff[lw_dest] = 1'b0;
        stall = 1'b0;
        sel   = '0;
        for (int i = 0; i < NSRC; i++) begin
            r   = ds_raddr[i*AW +: AW];
            hit = -1;
            for (int s = NSTG - 1; s >= 0; s--)
                if (ds_ren[i] && r != 0 && st_valid[s] && st_we[s] && st_dest[s*AW +: AW] == r)
                    hit = s;
            if (hit >= 0) begin
                sel[i*SW + hit] = 1'b1;
                if (!st_rdy[hit]) stall = 1'b1;
            end else begin
                sel[i*SW + NSTG] = 1'b1;
                if (ds_ren[i] && r != 0 && eff[r]) stall = 1'b1;
            end
        end
        if (ds_we && ds_dest != 0 && eff[ds_dest]) stall = 1'b1;
        if (ds_long && ds_we && $countones(eff) == NLONG) stall = 1'b1;
        if (flush) begin
            sbn = '0;
            fwn = RF_ALL;
        end else begin
            sbn = eff;
            fwn = m_fw;
            if (ds_issue && !stall) begin
                fwn = sel;
                if (ds_long && ds_we && ds_dest != 0) sbn[ds_dest] = 1'b1;
            end
        end
    endtask

    // Called just after a rising edge with inputs already driven
    task automatic cycle(input string tag);
        exp_t e;
        logic st;
        #2;
        model_eval(st, e.sb, e.fw);
        check_val({tag, ".stall"}, {31'd0, ds_stall}, {31'd0, st});
        e.tag = tag;
        e.cnt = $countones(e.sb);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_val({e.tag, ".fw"}, {24'd0, fw_sel}, {24'd0, e.fw});
        check_val({e.tag, ".cnt"}, {29'd0, sb_cnt}, e.cnt);
        m_sb = e.sb;
        m_fw = e.fw;
    endtask

    task automatic issue_long(input logic [4:0] r, input string tag);
        idle();
        ds_issue = 1'b1; ds_long = 1'b1; ds_we = 1'b1; ds_dest = r;
        cycle(tag);
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        m_sb   = '0;
        m_fw   = RF_ALL;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.cnt", {29'd0, sb_cnt}, 0);
        check_val("rst.fw", {24'd0, fw_sel}, {24'd0, RF_ALL});
        check_val("rst.stall", {31'd0, ds_stall}, 0);
        resetn = 1'b1;

        // Stage 0 forwards r5 to port 0
        idle();
        st_valid = 3'b001; st_we = 3'b001; st_rdy = 3'b001; st_dest = 15'd5;
        ds_ren = 2'b01; ds_raddr = 10'd5; ds_issue = 1'b1;
        cycle("fwd5");
        check_val("fwd5.sel", {24'd0, fw_sel}, 32'h81);

        // Stages 0 and 2 both write r7: youngest wins, then not-ready stalls
        idle();
        st_valid = 3'b101; st_we = 3'b101; st_rdy = 3'b111;
        st_dest = {5'd7, 5'd0, 5'd7};
        ds_ren = 2'b10; ds_raddr = {5'd7, 5'd0}; ds_issue = 1'b1;
        cycle("prio7");
        check_val("prio7.sel", {24'd0, fw_sel}, 32'h18);
        st_rdy = 3'b110;
        #2;
        check_val("notrdy.stall", {31'd0, ds_stall}, 1);
        cycle("notrdy");
        check_val("notrdy.hold", {24'd0, fw_sel}, 32'h18);

        // Long op to r9, read without a stage match, then completion
        issue_long(5'd9, "l9");
        check_val("l9.cnt", {29'd0, sb_cnt}, 1);
        idle();
        ds_ren = 2'b01; ds_raddr = 10'd9; ds_issue = 1'b1;
        #2;
        check_val("rd9.stall", {31'd0, ds_stall}, 1);
        cycle("rd9");
        idle();
        ds_ren = 2'b01; ds_raddr = 10'd9; lw_done = 1'b1; lw_dest = 5'd9;
        cycle("lw9");
        idle();
        ds_ren = 2'b01; ds_raddr = 10'd9;
        #2;
        check_val("rd9b.stall", {31'd0, ds_stall}, 0);
        cycle("rd9b");
        check_val("rd9b.cnt", {29'd0, sb_cnt}, 0);

        // Fill the scoreboard, stall on the fifth, same-cycle clear+set of r2
        for (int r = 1; r <= 4; r++) issue_long(5'(r), "fill");
        check_val("fill.cnt", {29'd0, sb_cnt}, 4);
        idle();
        ds_issue = 1'b1; ds_long = 1'b1; ds_we = 1'b1; ds_dest = 5'd5;
        #2;
        check_val("full.stall", {31'd0, ds_stall}, 1);
        cycle("full");
        idle();
        ds_issue = 1'b1; ds_long = 1'b1; ds_we = 1'b1; ds_dest = 5'd2;
        lw_done = 1'b1; lw_dest = 5'd2;
        cycle("setclr");
        check_val("setclr.cnt", {29'd0, sb_cnt}, 4);
        idle();
        ds_ren = 2'b01; ds_raddr = 10'd2;
        #2;
        check_val("sb2.stall", {31'd0, ds_stall}, 1);
        cycle("sb2");
        for (int r = 1; r <= 4; r++) begin
            idle();
            lw_done = 1'b1; lw_dest = 5'(r);
            cycle("drain");
        end
        check_val("drain.cnt", {29'd0, sb_cnt}, 0);

        // Register 0 never forwards and never reserves
        idle();
        st_valid = 3'b001; st_we = 3'b001; st_rdy = 3'b000; st_dest = '0;
        ds_ren = 2'b01; ds_raddr = '0; ds_issue = 1'b1;
        #2;
        check_val("r0.stall", {31'd0, ds_stall}, 0);
        cycle("r0");
        check_val("r0.sel", {28'd0, fw_sel[3:0]}, 32'h8);
        issue_long(5'd0, "l0");
        check_val("l0.cnt", {29'd0, sb_cnt}, 0);

        // Flush overrides a same-cycle issue
        for (int r = 1; r <= 3; r++) issue_long(5'(r), "pre_fl");
        check_val("pre_fl.cnt", {29'd0, sb_cnt}, 3);
        issue_long(5'd4, "dummy_unused");
        idle();
        lw_done = 1'b1; lw_dest = 5'd4;
        cycle("unl4");
        idle();
        ds_issue = 1'b1; ds_long = 1'b1; ds_we = 1'b1; ds_dest = 5'd6; flush = 1'b1;
        cycle("flush");
        check_val("flush.cnt", {29'd0, sb_cnt}, 0);
        check_val("flush.fw", {24'd0, fw_sel}, {24'd0, RF_ALL});
        idle();
        ds_ren = 2'b11; ds_raddr = {5'd1, 5'd2};
        cycle("postfl");

        // Asynchronous reset mid-cycle
        for (int r = 1; r <= 3; r++) issue_long(5'(r), "pre_rst");
        check_val("pre_rst.cnt", {29'd0, sb_cnt}, 3);
        idle();
        #3;
        resetn = 1'b0;
        #1;
        check_val("arst.cnt", {29'd0, sb_cnt}, 0);
        check_val("arst.fw", {24'd0, fw_sel}, {24'd0, RF_ALL});
        check_val("arst.stall", {31'd0, ds_stall}, 0);
        m_sb = '0;
        m_fw = RF_ALL;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ds_ren = 2'b11; ds_raddr = {5'd1, 5'd3};
        cycle("postrst");

        // Random traffic against the reference behaviour
        for (int n = 0; n < 300; n++) begin
            idle();
            st_valid = 3'($urandom);
            st_we    = 3'($urandom);
            st_rdy   = 3'($urandom);
            for (int s = 0; s < NSTG; s++) st_dest[s*AW +: AW] = 5'($urandom_range(0, 7));
            for (int i = 0; i < NSRC; i++) ds_raddr[i*AW +: AW] = 5'($urandom_range(0, 7));
            ds_ren   = 2'($urandom);
            ds_issue = ($urandom_range(0, 3) != 0);
            ds_we    = ($urandom_range(0, 3) != 0);
            ds_long  = ($urandom_range(0, 2) == 0);
            ds_dest  = 5'($urandom_range(0, 7));
            lw_done  = ($urandom_range(0, 2) == 0);
            lw_dest  = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 39) == 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
